// File: rtl/hazard_detection_unit.sv
// Hazard detection and pipeline control for a 5-stage pipeline whose
// branches resolve in ID. The block produces stall (bubble), freeze
// (data memory busy) and redirect (IF/ID flush) controls, and counts
// bubble cycles and redirects in saturating counters.
//
// Control precedence each cycle: reset > freeze > stall > redirect.
// All control outputs are combinational in the current state, rem and
// inputs, so they are valid in the same cycle with no latency.
module hazard_detection_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemRead_ID_EX,
  input  logic             RegWrite_ID_EX,
  input  logic [4:0]       RegDst_ID_EX,
  input  logic             MemRead_EX_MEM,
  input  logic [4:0]       RegRD_EX_MEM,
  input  logic [4:0]       RegRS_IF_ID,
  input  logic [4:0]       RegRT_IF_ID,
  input  logic             UsesRT_IF_ID,
  input  logic             Branch_ID,
  input  logic             BranchTaken_ID,
  input  logic             MemBusy,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             PipeFreeze,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2
  } state_t;

  state_t     state;
  state_t     nextState;
  logic [1:0] rem;
  logic [1:0] nextRem;
  logic [1:0] need;
  logic       exMatch;
  logic       memMatch;
  logic       stallNow;
  logic       freezeNow;

  // True when a producer register feeds one of the ID sources; r0 never does.
  function automatic logic srcMatch(input logic [4:0] r,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt,
                                    input logic       usesRt);
    srcMatch = (r != 5'd0) && ((r == rs) || (usesRt && (r == rt)));
  endfunction

  // Number of bubble cycles the ID instruction needs, as seen in RUN.
  always_comb begin
    exMatch  = srcMatch(RegDst_ID_EX, RegRS_IF_ID, RegRT_IF_ID, UsesRT_IF_ID);
    memMatch = srcMatch(RegRD_EX_MEM, RegRS_IF_ID, RegRT_IF_ID, UsesRT_IF_ID);
    need     = 2'd0;
    if (Branch_ID && MemRead_ID_EX && exMatch) begin
      need = 2'd2;
    end else if (MemRead_ID_EX && exMatch) begin
      need = 2'd1;
    end else if (Branch_ID && RegWrite_ID_EX && exMatch) begin
      need = 2'd1;
    end else if (Branch_ID && MemRead_EX_MEM && memMatch) begin
      need = 2'd1;
    end
  end

  // State and remaining-stall register; reset drops any stall in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      rem   <= 2'd0;
    end else begin
      state <= nextState;
      rem   <= nextRem;
    end
  end

  // Next state: FREEZE exits straight into the RUN rules on the same cycle.
  always_comb begin
    nextState = state;
    nextRem   = rem;
    case (state)
      STALL: begin
        if (!MemBusy) begin
          nextRem   = (rem == 2'd0) ? 2'd0 : rem - 2'd1;
          nextState = (rem <= 2'd1) ? RUN : STALL;
        end
      end
      default: begin
        if (MemBusy) begin
          nextState = FREEZE;
        end else if (need != 2'd0) begin
          nextRem   = need - 2'd1;
          nextState = (need > 2'd1) ? STALL : RUN;
        end else begin
          nextState = RUN;
        end
      end
    endcase
  end

  // Pipeline controls with precedence reset > freeze > stall > redirect.
  always_comb begin
    freezeNow   = MemBusy;
    stallNow    = !MemBusy && ((state == STALL) || (need != 2'd0));
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = BranchTaken_ID;
    ID_EX_Flush = 1'b0;
    PipeFreeze  = 1'b0;
    if (rst) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (freezeNow) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b0;
      PipeFreeze  = 1'b1;
    end else if (stallNow) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b0;
      ID_EX_Flush = 1'b1;
    end
  end

  // Saturating count of bubble cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCycles <= '0;
    end else if (ID_EX_Flush && (StallCycles != {CNT_W{1'b1}})) begin
      StallCycles <= StallCycles + CNT_W'(1);
    end
  end

  // Saturating count of redirect (IF/ID flush) cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      FlushCount <= '0;
    end else if (IF_ID_Flush && (FlushCount != {CNT_W{1'b1}})) begin
      FlushCount <= FlushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit: a per-cycle vector table run
// from reset, then hand-written sequences for counter saturation and
// asynchronous reset in the middle of a stall.
module tb_hazard_detection_unit;

  logic        clk;
  logic        rst;
  logic        memReadEx;
  logic        regWriteEx;
  logic [4:0]  regDstEx;
  logic        memReadMem;
  logic [4:0]  regRdMem;
  logic [4:0]  regRs;
  logic [4:0]  regRt;
  logic        usesRt;
  logic        branch;
  logic        branchTaken;
  logic        memBusy;

  logic        pcWrite, ifIdWrite, ifIdFlush, idExFlush, pipeFreeze;
  logic [15:0] stallCycles, flushCount;
  logic        pcWrite4, ifIdWrite4, ifIdFlush4, idExFlush4, pipeFreeze4;
  logic [3:0]  stallCycles4, flushCount4;

  int testsRun;
  int testsFailed;

  // Expected control patterns {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PipeFreeze}
  localparam logic [4:0] O_NORM  = 5'b11000;
  localparam logic [4:0] O_REDIR = 5'b11100;
  localparam logic [4:0] O_STALL = 5'b00010;
  localparam logic [4:0] O_FRZ   = 5'b00001;
  localparam logic [4:0] O_RST   = 5'b00110;

  typedef struct {
    logic       mrEx;
    logic       rwEx;
    logic [4:0] dstEx;
    logic       mrMem;
    logic [4:0] rdMem;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       useRt;
    logic       br;
    logic       taken;
    logic       busy;
    logic [4:0] expOut;
    int         expStall;
    int         expFlush;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs[NVEC];

  hazard_detection_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .MemRead_ID_EX(memReadEx), .RegWrite_ID_EX(regWriteEx), .RegDst_ID_EX(regDstEx),
    .MemRead_EX_MEM(memReadMem), .RegRD_EX_MEM(regRdMem),
    .RegRS_IF_ID(regRs), .RegRT_IF_ID(regRt), .UsesRT_IF_ID(usesRt),
    .Branch_ID(branch), .BranchTaken_ID(branchTaken), .MemBusy(memBusy),
    .PCWrite(pcWrite), .IF_ID_Write(ifIdWrite), .IF_ID_Flush(ifIdFlush),
    .ID_EX_Flush(idExFlush), .PipeFreeze(pipeFreeze),
    .StallCycles(stallCycles), .FlushCount(flushCount)
  );

  hazard_detection_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .MemRead_ID_EX(memReadEx), .RegWrite_ID_EX(regWriteEx), .RegDst_ID_EX(regDstEx),
    .MemRead_EX_MEM(memReadMem), .RegRD_EX_MEM(regRdMem),
    .RegRS_IF_ID(regRs), .RegRT_IF_ID(regRt), .UsesRT_IF_ID(usesRt),
    .Branch_ID(branch), .BranchTaken_ID(branchTaken), .MemBusy(memBusy),
    .PCWrite(pcWrite4), .IF_ID_Write(ifIdWrite4), .IF_ID_Flush(ifIdFlush4),
    .ID_EX_Flush(idExFlush4), .PipeFreeze(pipeFreeze4),
    .StallCycles(stallCycles4), .FlushCount(flushCount4)
  );

  // Clock: period 10, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic mrEx, input logic rwEx, input logic [4:0] dstEx,
                              input logic mrMem, input logic [4:0] rdMem,
                              input logic [4:0] rs, input logic [4:0] rt, input logic useRt,
                              input logic br, input logic taken, input logic busy,
                              input logic [4:0] expOut, input int expStall, input int expFlush);
    vec_t v;
    v.mrEx = mrEx; v.rwEx = rwEx; v.dstEx = dstEx; v.mrMem = mrMem; v.rdMem = rdMem;
    v.rs = rs; v.rt = rt; v.useRt = useRt; v.br = br; v.taken = taken; v.busy = busy;
    v.expOut = expOut; v.expStall = expStall; v.expFlush = expFlush;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkOut(input string tag, input logic [4:0] exp);
    chk({tag, ".ctrl"}, int'({pcWrite, ifIdWrite, ifIdFlush, idExFlush, pipeFreeze}), int'(exp));
  endtask

  task automatic applyVec(input vec_t v);
    memReadEx   = v.mrEx;  regWriteEx = v.rwEx; regDstEx = v.dstEx;
    memReadMem  = v.mrMem; regRdMem   = v.rdMem;
    regRs       = v.rs;    regRt      = v.rt;   usesRt   = v.useRt;
    branch      = v.br;    branchTaken = v.taken; memBusy = v.busy;
  endtask

  task automatic idleInputs();
    applyVec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0, 0));
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    // One row per cycle, starting from reset; counters are the values seen
    // during that cycle, i.e. before its closing clock edge.
    //                 mrEx rw dst mrM rdM rs rt uRt br tkn busy expect  sc fc
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,  0, 0); // idle
    vecs[1]  = mk(1, 0, 5, 0, 0, 5, 0, 0, 0, 0, 0, O_STALL, 0, 0); // load-use on rs
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,  1, 0); // bubble, one stall only
    vecs[3]  = mk(1, 0, 8, 0, 0, 0, 8, 1, 1, 0, 0, O_STALL, 1, 0); // branch on load via rt
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_STALL, 2, 0); // second stall, inputs idle
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,  3, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,  3, 0); // r0 never hazards
    vecs[7]  = mk(1, 0, 9, 0, 0, 1, 9, 0, 0, 0, 0, O_NORM,  3, 0); // rt match, rt unused
    vecs[8]  = mk(0, 1, 3, 0, 0, 3, 0, 0, 1, 0, 0, O_STALL, 3, 0); // branch on ALU result in EX
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,  4, 0);
    vecs[10] = mk(0, 1, 3, 0, 0, 3, 0, 0, 0, 0, 0, O_NORM,  4, 0); // ALU result, no branch
    vecs[11] = mk(0, 0, 0, 1, 7, 0, 7, 1, 1, 0, 0, O_STALL, 4, 0); // branch on load in MEM
    vecs[12] = mk(0, 0, 0, 1, 7, 7, 0, 0, 0, 0, 0, O_NORM,  5, 0); // load in MEM, no branch
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_REDIR, 5, 0); // redirect
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,  5, 1);
    vecs[15] = mk(1, 0, 5, 0, 0, 5, 0, 0, 0, 1, 0, O_STALL, 5, 1); // redirect ignored in stall
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,  6, 1);
    vecs[17] = mk(1, 0, 5, 0, 0, 5, 0, 0, 0, 1, 1, O_FRZ,   6, 1); // freeze beats stall+redirect
    vecs[18] = mk(1, 0, 5, 0, 0, 5, 0, 0, 0, 0, 0, O_STALL, 6, 1); // leaving FREEZE runs RUN rules
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,  7, 1);
    vecs[20] = mk(1, 0, 8, 0, 0, 0, 8, 1, 1, 0, 0, O_STALL, 7, 1); // 2-cycle stall starts
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_FRZ,   8, 1); // freeze inside stall
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_FRZ,   8, 1);
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_FRZ,   8, 1);
    vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_STALL, 8, 1); // remaining stall resumes
    vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,  9, 1);
    vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_REDIR, 9, 1);
    vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,  9, 2);

    // Reset block
    rst = 1'b1;
    idleInputs();
    #12;
    chkOut("reset", O_RST);
    chk("reset.StallCycles", int'(stallCycles), 0);
    chk("reset.FlushCount", int'(flushCount), 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < NVEC; i++) begin
      applyVec(vecs[i]);
      @(negedge clk);
      chkOut($sformatf("v%0d", i), vecs[i].expOut);
      chk($sformatf("v%0d.StallCycles", i), int'(stallCycles), vecs[i].expStall);
      chk($sformatf("v%0d.FlushCount", i), int'(flushCount), vecs[i].expFlush);
      @(posedge clk); #1;
    end

    // Twenty redirects: the 4-bit counter must stop at 15, the 16-bit one keeps counting
    for (int i = 0; i < 20; i++) begin
      idleInputs();
      branchTaken = 1'b1;
      @(negedge clk);
      chk($sformatf("sat%0d.IF_ID_Flush", i), int'(ifIdFlush4), 1);
      @(posedge clk); #1;
    end
    idleInputs();
    @(negedge clk);
    chk("sat.FlushCount4", int'(flushCount4), 15);
    chk("sat.FlushCount16", int'(flushCount), 22);
    chk("sat.StallCycles4", int'(stallCycles4), 9);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a 2-cycle stall
    applyVec(mk(1, 0, 8, 0, 0, 0, 8, 1, 1, 0, 0, O_STALL, 0, 0));
    @(negedge clk);
    chkOut("arst.first", O_STALL);
    @(posedge clk); #1;
    idleInputs();
    #2;
    chkOut("arst.inStall", O_STALL);
    rst = 1'b1;
    #1;
    chkOut("arst.asserted", O_RST);
    chk("arst.StallCycles", int'(stallCycles), 0);
    chk("arst.FlushCount", int'(flushCount), 0);
    chk("arst.FlushCount4", int'(flushCount4), 0);
    @(posedge clk); #1;
    chkOut("arst.held", O_RST);
    rst = 1'b0;
    #1;
    chkOut("arst.released", O_NORM);
    @(posedge clk); #1;
    chkOut("arst.nextCycle", O_NORM);
    chk("arst.StallCyclesAfter", int'(stallCycles), 0);
    chk("arst.FlushCountAfter", int'(flushCount), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/hazard_detection_unit.md
HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of each performance counter.
REQ-002 The block SHALL have port clk, input, 1, the rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, the reset; it is asynchronous and active-high.
REQ-004 The block SHALL have port MemRead_ID_EX, input, 1, which flags a load in EX.
REQ-005 The block SHALL have port RegWrite_ID_EX, input, 1, which flags that the EX instruction writes a register.
REQ-006 The block SHALL have port RegDst_ID_EX, input, 5, the EX destination register (rt for loads).
REQ-007 The block SHALL have port MemRead_EX_MEM, input, 1, which flags a load in MEM.
REQ-008 The block SHALL have port RegRD_EX_MEM, input, 5, the MEM destination register.
REQ-009 The block SHALL have port RegRS_IF_ID, input, 5, the ID source register rs.
REQ-010 The block SHALL have port RegRT_IF_ID, input, 5, the ID source register rt.
REQ-011 The block SHALL have port UsesRT_IF_ID, input, 1, which flags that the ID instruction reads rt.
REQ-012 The block SHALL have port Branch_ID, input, 1, which flags a branch in ID (resolved in ID).
REQ-013 The block SHALL have port BranchTaken_ID, input, 1, the branch/jump redirect request from ID.
REQ-014 The block SHALL have port MemBusy, input, 1, which indicates the data memory has not completed this cycle.
REQ-015 The block SHALL have port PCWrite, output, 1, the PC update enable.
REQ-016 The block SHALL have port IF_ID_Write, output, 1, the IF/ID register enable.
REQ-017 The block SHALL have port IF_ID_Flush, output, 1, which zeroes IF/ID.
REQ-018 The block SHALL have port ID_EX_Flush, output, 1, which inserts a bubble into ID/EX.
REQ-019 The block SHALL have port PipeFreeze, output, 1, which holds ID/EX, EX/MEM and MEM/WB.
REQ-020 The block SHALL have port StallCycles, output, CNT_W, the count of bubble cycles.
REQ-021 The block SHALL have port FlushCount, output, CNT_W, the count of redirects.

Function
REQ-022 Define srcmatch(r) = (r != 0) & ((r == RegRS_IF_ID) | (UsesRT_IF_ID & r == RegRT_IF_ID)).
REQ-023 Define need as follows:
- need = 2 if Branch_ID & MemRead_ID_EX & srcmatch(RegDst_ID_EX);
- else need = 1 if MemRead_ID_EX & srcmatch(RegDst_ID_EX);
- else need = 1 if Branch_ID & RegWrite_ID_EX & srcmatch(RegDst_ID_EX);
- else need = 1 if Branch_ID & MemRead_EX_MEM & srcmatch(RegRD_EX_MEM);
- else need = 0.
REQ-024 The FSM SHALL have states RUN, STALL and FREEZE, plus a 2-bit register rem.
REQ-025 RUN transitions SHALL be:
- if MemBusy: go to FREEZE;
- else if need > 0: stall this cycle, rem <= need-1, and go to STALL if need-1 > 0, otherwise stay in RUN;
- else stay in RUN.
REQ-026 In STALL, the block SHALL stall unconditionally without re-evaluating need, decrement rem, and return to RUN when rem reaches 0.
REQ-027 In STALL with MemBusy=1, the block SHALL freeze instead, keep rem unchanged, and stay in STALL.
REQ-028 FREEZE SHALL be left for RUN on the first cycle MemBusy=0, and the RUN rules SHALL be evaluated in that same cycle.
REQ-029 Stall outputs SHALL be PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0, PipeFreeze=0.
REQ-030 Freeze outputs (MemBusy=1 in any state) SHALL be PCWrite=0, IF_ID_Write=0, ID_EX_Flush=0, IF_ID_Flush=0, PipeFreeze=1.
REQ-031 Normal outputs SHALL be PCWrite=1, IF_ID_Write=1, ID_EX_Flush=0, PipeFreeze=0, IF_ID_Flush=BranchTaken_ID.
REQ-032 Priority SHALL be freeze > stall > redirect; BranchTaken_ID SHALL be ignored in any cycle that stalls or freezes.
REQ-033 All outputs SHALL be combinational from state, rem and inputs; they are valid in the same cycle, with zero latency.
REQ-034 StallCycles SHALL increment on each cycle with ID_EX_Flush=1 and saturate at all-ones.
REQ-035 FlushCount SHALL increment on each cycle with IF_ID_Flush=1 and saturate at all-ones.
REQ-036 Register index 0 SHALL never create a hazard.

Reset
REQ-037 While rst=1, the outputs SHALL be PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, PipeFreeze=0.
REQ-038 Asserting rst SHALL immediately set the state to RUN, rem=0, StallCycles=0 and FlushCount=0, including in mid-STALL or mid-FREEZE.
REQ-039 After rst is deasserted, the first rising edge SHALL evaluate the RUN rules with no residual stall.

Verification
REQ-040 Load-use: the bench SHALL apply MemRead_ID_EX=1, RegDst_ID_EX=5, RegRS_IF_ID=5, then a bubble next cycle -> exactly 1 cycle of PCWrite=0/ID_EX_Flush=1, with StallCycles=1.
REQ-041 Branch-on-load: the bench SHALL apply Branch_ID=1, MemRead_ID_EX=1, RegDst_ID_EX=8, RegRT_IF_ID=8, UsesRT_IF_ID=1 -> 2 consecutive stall cycles even though the inputs return to 0 after the first cycle, with StallCycles=2.
REQ-042 Zero register and unused rt: the bench SHALL apply RegDst_ID_EX=0 matching rs, then RegDst_ID_EX=9 matching rt with UsesRT_IF_ID=0 -> no stall in either case.
REQ-043 Freeze inside stall: the bench SHALL start a 2-cycle branch-on-load stall and raise MemBusy for 3 cycles after the first stall cycle -> 1 stall, then 3 freeze cycles (PipeFreeze=1, ID_EX_Flush=0), then 1 stall, then normal operation.
REQ-044 Redirect and saturation: the bench SHALL apply BranchTaken_ID=1 with no hazard -> IF_ID_Flush=1 and FlushCount+1; the same request during a stall -> IF_ID_Flush=0; with CNT_W=4 and 20 redirects -> FlushCount=15.
REQ-045 Async reset: the bench SHALL assert rst mid-STALL between clock edges -> the outputs take their reset values immediately and the counters read 0; after release, the first cycle with no hazard gives PCWrite=1.
